ex_mem_redirect: RTL
====================

// Module: ex_mem_redirect
// PURPOSE
//  EX/MEM-side branch/jump resolution stage; produces the fetch-redirect pair ex_mem_pc_src/ex_mem_npc consumed by fetchTop.
//  Compares operands, computes branch/jump target, registers a one-cycle redirect pulse, then squashes wrong-path instructions.
//  Sits between the ID/EX pipeline register and the fetch unit; single clock domain.
// PARAMETERS
//  FLUSH_DEPTH   2   wrong-path instructions squashed after a redirect (IF/ID + ID/EX); legal 1..7
//  BR_SHIFT      2   left shift applied to id_ex_imm for branch offset (word addressing)
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-low reset
//  stall          in   1   pipeline hold; stage state frozen while high
//  id_ex_valid    in   1   instruction in ID/EX is real (not bubble)
//  id_ex_npc      in   32  PC+4 of the instruction
//  id_ex_imm      in   32  sign-extended branch immediate
//  id_ex_rs_val   in   32  operand A
//  id_ex_rt_val   in   32  operand B
//  id_ex_beq      in   1   branch if A==B
//  id_ex_bne      in   1   branch if A!=B
//  id_ex_jump     in   1   unconditional jump
//  id_ex_jidx     in   26  jump index field
//  ex_mem_pc_src  out  1   redirect fetch this cycle (one-cycle pulse)
//  ex_mem_npc     out  32  redirect target (meaningful only when ex_mem_pc_src=1)
//  ex_mem_flush   out  1   squash IF/ID and ID/EX contents (high while squashing)
//  ex_mem_valid   out  1   registered: instruction now in EX/MEM is real
// BEHAVIOUR
//  Reset (rst=0, async): ex_mem_pc_src=0, ex_mem_npc=0, ex_mem_flush=0, ex_mem_valid=0, state=RUN, sq_cnt=0.
//  Latency: inputs sampled at rising edge; outputs registered, visible 1 cycle later.
//  take = id_ex_valid & ~squash & (id_ex_jump | (id_ex_beq & A==B) | (id_ex_bne & A!=B)).
//  Target: jump -> {id_ex_npc[31:28], id_ex_jidx, 2'b00}; branch -> id_ex_npc + (id_ex_imm << BR_SHIFT), mod 2^32 (wrap, no trap).
//  Priority if several flags set: jump > beq > bne.
//  ex_mem_npc updates only on a taken edge; holds last target otherwise.
//  ex_mem_pc_src: high exactly one cycle per taken instruction; never two consecutive cycles.
//  ex_mem_valid <= id_ex_valid & ~squash (when not stalled).
//  FSM:
//   RUN:    take -> SQUASH, sq_cnt<=FLUSH_DEPTH, pc_src<=1; else stay, pc_src<=0.
//   SQUASH: each non-stalled edge: sq_cnt<=sq_cnt-1, pc_src<=0; inputs treated as invalid (no take, valid<=0);
//           sq_cnt reaching 0 -> RUN.
//   ex_mem_flush = (state==SQUASH).
//  stall=1: state, sq_cnt, ex_mem_npc, ex_mem_valid hold; ex_mem_pc_src forced 0 next edge (pulse not repeated);
//   a take presented during stall is evaluated on first non-stalled edge.
//  Branch on squashed (wrong-path) instruction: ignored, no redirect.
//  Reset asserted mid-SQUASH: immediate return to RUN, counters and outputs cleared.
//  id_ex_valid=0 with branch flags set: no redirect.
// TESTING
//  1 Reset: rst=0 mid-run with random inputs -> all outputs 0 immediately, stay 0 until release.
//  2 BEQ taken: npc=0x10, imm=0x4, A=B=5 -> next cycle pc_src=1 for 1 cycle, npc=0x20; flush high 2 cycles; valid=0 for 2 cycles.
//  3 BNE not taken: npc=0x10, imm=0x3, A=B -> pc_src stays 0, valid=1, flush=0; then A!=B -> npc=0x1C.
//  4 Jump: npc=0x8000_0004, jidx=0x000_000F -> npc=0x8000_003C, pc_src pulse; wrong-path beq behind it ignored.
//  5 Wrap/backward: npc=0x4, imm=0xFFFF_FFFE -> target 0xFFFF_FFFC; npc=0x10, imm=-2 -> 0x8.
//  6 Stall during SQUASH: stall 3 cycles after redirect -> flush held, sq_cnt frozen, pc_src not re-pulsed; resumes count on release.

Source files
------------

// File: rtl/ex_mem_redirect.sv
// EX/MEM branch/jump resolution: registers a one-cycle fetch redirect and
// squashes the wrong-path instructions that follow it.
module ex_mem_redirect #(
  parameter int FLUSH_DEPTH = 2,
  parameter int BR_SHIFT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_npc,
  input  logic [31:0] id_ex_imm,
  input  logic [31:0] id_ex_rs_val,
  input  logic [31:0] id_ex_rt_val,
  input  logic        id_ex_beq,
  input  logic        id_ex_bne,
  input  logic        id_ex_jump,
  input  logic [25:0] id_ex_jidx,
  output logic        ex_mem_pc_src,
  output logic [31:0] ex_mem_npc,
  output logic        ex_mem_flush,
  output logic        ex_mem_valid
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sq_cnt_q, sq_cnt_d;
  logic        pc_src_q, pc_src_d;
  logic [31:0] npc_q, npc_d;
  logic        valid_q, valid_d;

  logic        squash;
  logic        ops_eq;
  logic        take;
  logic [31:0] target;

  always_comb begin
    squash = (state_q == SQUASH);
    ops_eq = (id_ex_rs_val == id_ex_rt_val);
    take   = id_ex_valid & ~squash &
             (id_ex_jump | (id_ex_beq & ops_eq) | (id_ex_bne & ~ops_eq));
    // Jump wins over branches; both branch kinds share the same offset target.
    if (id_ex_jump) target = {id_ex_npc[31:28], id_ex_jidx, 2'b00};
    else            target = id_ex_npc + (id_ex_imm << BR_SHIFT);
  end

  always_comb begin
    state_d  = state_q;
    sq_cnt_d = sq_cnt_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    pc_src_d = 1'b0;
    if (!stall) begin
      valid_d = id_ex_valid & ~squash;
      case (state_q)
        RUN: begin
          if (take) begin
            state_d  = SQUASH;
            sq_cnt_d = 3'(FLUSH_DEPTH);
            pc_src_d = 1'b1;
            npc_d    = target;
          end
        end
        SQUASH: begin
          sq_cnt_d = sq_cnt_q - 3'd1;
          if (sq_cnt_q == 3'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= RUN;
      sq_cnt_q <= 3'd0;
      pc_src_q <= 1'b0;
      npc_q    <= 32'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sq_cnt_q <= sq_cnt_d;
      pc_src_q <= pc_src_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
    end
  end

  assign ex_mem_pc_src = pc_src_q;
  assign ex_mem_npc    = npc_q;
  assign ex_mem_flush  = (state_q == SQUASH);
  assign ex_mem_valid  = valid_q;

endmodule
